booth_issue_ctrl: RTL and testbench
===================================

// Module: booth_issue_ctrl
// PURPOSE
//  Sits directly upstream of the sequential Booth multiplier top. Buffers operand pairs from a
//  valid/ready producer, issues one start pulse per pair, and holds the operands stable until done.
//  Captures the signed 32-bit product and presents it to a valid/ready consumer.
//  Serialises back-to-back requests into the multi-cycle, non-pipelined multiplier.
// PARAMETERS
//  W        16   operand width; the product is 2*W bits
//  DEPTH    4    operand FIFO entries; power of 2, >=2
//  TIMEOUT  64   cycles allowed from mul_start to mul_done before the job is aborted
// PORTS
//  clk              in   1     single clock, rising edge
//  rst              in   1     asynchronous, active-low reset
//  in_valid         in   1     operand pair offered
//  in_ready         out  1     FIFO not full
//  in_a             in   W     signed multiplicand
//  in_b             in   W     signed multiplier
//  mul_start        out  1     1-cycle start pulse to the multiplier
//  mul_multiplicand out  W     registered operand, stable from start until done is captured
//  mul_multiplier   out  W     registered operand, same stability rule
//  mul_done         in   1     multiplier done level
//  mul_result       in   2W    multiplier signed product
//  out_valid        out  1     product available
//  out_ready        in   1     consumer accepts the product
//  out_result       out  2W    signed product
//  out_err          out  1     qualifies out_valid: the job timed out; out_result is then 0
//  busy             out  1     FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, FIFO empty, and all outputs 0 except in_ready=1.
//  FIFO behaviour:
//   - A push occurs on in_valid&in_ready.
//   - A pop occurs on entry to LAUNCH or ZERO.
//   - Push and pop in the same cycle are both allowed, including when the FIFO is full.
//   - Pointers are log2(DEPTH)+1 bits and wrap naturally.
//  FSM states:
//   - IDLE: if the FIFO is non-empty, pop the head.
//     - If either operand is 0, go to ZERO.
//     - Otherwise register both operands onto the mul_* outputs and go to LAUNCH.
//   - LAUNCH: mul_start=1 for exactly one cycle, clear the watchdog, then go to WAIT.
//   - WAIT: increment the watchdog each cycle.
//     - mul_done is ignored in the first cycle of WAIT, which covers a stale done level from the
//       previous job.
//     - On the first qualified mul_done=1: register mul_result into out_result, out_err=0, go to HOLD.
//     - If the watchdog reaches TIMEOUT first: out_result=0, out_err=1, go to HOLD.
//   - ZERO: out_result=0, out_err=0, go to HOLD. The multiplier is not started.
//   - HOLD: out_valid=1.
//     - out_result and out_err stay stable until out_valid&out_ready.
//     - On that handshake, go to IDLE.
//     - Optional pop: if the FIFO is non-empty, pop directly into LAUNCH or ZERO, saving a cycle.
//  Timing:
//   - Latency, in_valid accept to out_valid: mul_done latency + 3 cycles.
//   - Zero-operand path: 3 cycles.
//  Operand and result rules:
//   - mul_* operands change only in IDLE/HOLD->LAUNCH transitions.
//   - The product is taken verbatim; sign handling, including -32768, belongs to the multiplier.
//  Edge cases:
//   - out_ready is ignored outside HOLD.
//   - in_valid is ignored when full.
//   - The FIFO may accept while the multiplier is busy.
// STRUCTURE
//  Shared package booth_pkg holds:
//   - state encoding localparams: IDLE, LAUNCH, WAIT, ZERO, HOLD
//   - W_DEF=16 and TIMEOUT_DEF=64
//  One sub-module, op_fifo (DEPTH x 2W, registered read head), instantiated once.
//  The FSM and watchdog counter are implemented in this module.
// TESTING
//  1. Reset mid-WAIT: assert rst=0 -> all outputs 0 and in_ready=1 immediately; the next job then runs normally.
//  2. Single job a=3, b=-5 with a 34-cycle multiplier model ->
//     one mul_start pulse, operands stable, out_result=-15, out_err=0.
//  3. Four pairs pushed back-to-back, out_ready=1 -> four start pulses, results in order; in_ready=0 after the 4th push.
//  4. a=0, b=1234 -> no mul_start; out_valid 3 cycles after accept with result 0.
//  5. Model never asserts done -> out_err=1 and out_result=0 after 64 WAIT cycles; the following job succeeds.
//  6. out_ready held 0 for 10 cycles in HOLD -> out_result stable, no new mul_start;
//     stale mul_done=1 at LAUNCH+1 is not captured.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier issue controller.
//   state_t     : issue FSM states (IDLE, LAUNCH, WAIT, ZERO, HOLD)
//   W_DEF       : default operand width
//   TIMEOUT_DEF : default watchdog limit, in WAIT cycles
package booth_pkg;

  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    ZERO   = 3'd3,
    HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/op_fifo.sv
// Operand FIFO: DEPTH entries of WIDTH bits, head presented from the storage
// registers so the consumer sees it without a read cycle.
//   clk, rst      : clock, asynchronous active-low reset (pointers only)
//   push, wdata   : write request and data; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop           : remove the head entry (ignored when empty)
//   rdata         : current head entry
//   empty, full   : occupancy flags
module op_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // One extra pointer bit separates the full and empty cases when the
  // index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issue controller in front of a sequential, non-pipelined Booth multiplier.
// Buffers operand pairs, launches one multiplication at a time, guards each
// job with a watchdog, and hands the product to a valid/ready consumer.
//   clk, rst                          : clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b       : operand pair producer interface
//   mul_start                         : one-cycle start pulse to the multiplier
//   mul_multiplicand/mul_multiplier   : operands, held from start until capture
//   mul_done/mul_result               : multiplier completion level and product
//   out_valid/out_ready/out_result    : product consumer interface
//   out_err                           : job timed out, out_result forced to 0
//   busy                              : a job is in flight or operands are queued
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   in_a,
  input  logic signed [W-1:0]   in_b,
  output logic                  mul_start,
  output logic signed [W-1:0]   mul_multiplicand,
  output logic signed [W-1:0]   mul_multiplier,
  input  logic                  mul_done,
  input  logic signed [2*W-1:0] mul_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W-1:0] out_result,
  output logic                  out_err,
  output logic                  busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  state_t             state;
  state_t             next_state;
  logic [WDW-1:0]     wd;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [2*W-1:0]     head;
  logic signed [W-1:0] head_a;
  logic signed [W-1:0] head_b;
  logic               head_zero;

  logic               load_ops;
  logic               cap_result;
  logic               cap_timeout;
  logic               cap_zero;
  logic               done_qual;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  op_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign head_a    = head[2*W-1:W];
  assign head_b    = head[W-1:0];
  assign head_zero = (head_a == '0) || (head_b == '0);

  // The watchdog reads 0 only in the first WAIT cycle; a done level seen
  // then is left over from the previous job and must not be captured.
  assign done_qual = mul_done && (wd != '0);

  assign mul_start = (state == LAUNCH);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE) || ~fifo_empty;

  always_comb begin
    next_state  = state;
    fifo_pop    = 1'b0;
    load_ops    = 1'b0;
    cap_result  = 1'b0;
    cap_timeout = 1'b0;
    cap_zero    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_ops   = ~head_zero;
          next_state = head_zero ? ZERO : LAUNCH;
        end
      end
      LAUNCH: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (done_qual) begin
          cap_result = 1'b1;
          next_state = HOLD;
        end else if (wd == WD_LAST) begin
          cap_timeout = 1'b1;
          next_state  = HOLD;
        end
      end
      ZERO: begin
        cap_zero   = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          // Chain straight into the next queued job to save the IDLE cycle.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            load_ops   = ~head_zero;
            next_state = head_zero ? ZERO : LAUNCH;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Watchdog: cleared while the start pulse is out, counts WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd <= '0;
    end else if (state == LAUNCH) begin
      wd <= '0;
    end else if (state == WAIT) begin
      wd <= wd + WD_ONE;
    end
  end

  // Operand registers feeding the multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else if (load_ops) begin
      mul_multiplicand <= head_a;
      mul_multiplier   <= head_b;
    end
  end

  // Result registers, written only on entry to HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_result <= '0;
      out_err    <= 1'b0;
    end else if (cap_result) begin
      out_result <= mul_result;
      out_err    <= 1'b0;
    end else if (cap_timeout) begin
      out_result <= '0;
      out_err    <= 1'b1;
    end else if (cap_zero) begin
      out_result <= '0;
      out_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_issue_ctrl.sv
module tb_booth_issue_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               mul_start;
  logic signed [15:0] mul_multiplicand;
  logic signed [15:0] mul_multiplier;
  logic               mul_done;
  logic signed [31:0] mul_result;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_result;
  logic               out_err;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_issue_ctrl #(.W(16), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_done         (mul_done),
    .mul_result       (mul_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_err          (out_err),
    .busy             (busy)
  );

  // Multiplier model: done rises lat_cfg cycles after the start pulse cycle
  // and stays high until the next start (one cycle longer if stale_cfg).
  // lat_cfg = 0 means done never rises.
  int                 lat_cfg     = 5;
  bit                 stale_cfg   = 1'b0;
  int                 start_count = 0;
  int                 m_cnt;
  bit                 m_busy;
  bit                 m_clr;
  logic signed [31:0] m_pend;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_done   <= 1'b0;
      mul_result <= '0;
      m_busy     <= 1'b0;
      m_clr      <= 1'b0;
      m_cnt      <= 0;
      m_pend     <= '0;
    end else if (mul_start) begin
      start_count <= start_count + 1;
      m_pend <= $signed({{16{mul_multiplicand[15]}}, mul_multiplicand}) *
                $signed({{16{mul_multiplier[15]}}, mul_multiplier});
      m_cnt  <= lat_cfg - 1;
      m_busy <= (lat_cfg != 0);
      if (stale_cfg && mul_done) m_clr <= 1'b1;
      else mul_done <= 1'b0;
    end else begin
      if (m_clr) begin
        mul_done <= 1'b0;
        m_clr    <= 1'b0;
      end
      if (m_busy) begin
        if (m_cnt <= 1) begin
          mul_done   <= 1'b1;
          mul_result <= m_pend;
          m_busy     <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Operand stability monitor: from a start pulse until the product shows up,
  // the operands presented to the multiplier must not move.
  bit                 tracking   = 1'b0;
  bit                 op_changed = 1'b0;
  logic signed [15:0] rec_a;
  logic signed [15:0] rec_b;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      tracking <= 1'b0;
    end else if (mul_start) begin
      tracking <= 1'b1;
      rec_a    <= mul_multiplicand;
      rec_b    <= mul_multiplier;
    end else if (tracking) begin
      if (mul_multiplicand !== rec_a || mul_multiplier !== rec_b) op_changed <= 1'b1;
      if (out_valid) tracking <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic signed [31:0] ref_prod(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] ax;
    logic signed [31:0] bx;
    ax = a;
    bx = b;
    return ax * bx;
  endfunction

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    int                 lat;
    logic signed [31:0] res;
    logic               err;
    int                 cyc;
    int                 starts;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int s0;
    lat_cfg = v.lat;
    s0 = start_count;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(v.cyc));
    check({tag, "_result"}, out_result, v.res);
    check({tag, "_err"}, 32'(out_err), 32'(v.err));
    check({tag, "_starts"}, 32'(start_count - s0), 32'(v.starts));
    @(negedge clk);
    check({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  logic signed [15:0] burst_a[4] = '{-16'sd7, 16'sd100, 16'sd0, -16'sd32768};
  logic signed [15:0] burst_b[4] = '{16'sd9, -16'sd100, 16'sd5, -16'sd1};

  logic [31:0] exp_q[$];
  logic [31:0] op_q[$];

  task automatic rand_cycle(input bit drain);
    logic [31:0] e;
    logic [31:0] o;
    @(negedge clk);
    if (mul_start) begin
      if (op_q.size() == 0) begin
        check("rnd_start_unexpected", 32'd1, 32'd0);
      end else begin
        o = op_q.pop_front();
        check("rnd_start_ops", {mul_multiplicand, mul_multiplier}, o);
      end
    end
    out_ready = drain ? 1'b1 : ($urandom_range(0, 9) < 7);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("rnd_out_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_result", out_result, e);
        check("rnd_err", 32'(out_err), 32'd0);
      end
    end
    in_valid = drain ? 1'b0 : ($urandom_range(0, 9) < 6);
    in_a = ($urandom_range(0, 7) == 0) ? 16'sd0 :
           ($urandom_range(0, 15) == 0) ? -16'sd32768 : 16'($urandom);
    in_b = ($urandom_range(0, 7) == 0) ? 16'sd0 : 16'($urandom);
    if (in_valid && in_ready) begin
      exp_q.push_back((in_a == 0 || in_b == 0) ? 32'd0 : ref_prod(in_a, in_b));
      if (in_a != 0 && in_b != 0) op_q.push_back({in_a, in_b});
    end
    lat_cfg   = $urandom_range(2, 12);
    stale_cfg = $urandom_range(0, 1);
  endtask

  initial begin
    int s0;
    int n;
    vecs[0] = '{a:  16'sd3,     b: -16'sd5,     lat: 34, res: -32'sd15,        err: 1'b0, cyc: 37, starts: 1};
    vecs[1] = '{a:  16'sd0,     b:  16'sd1234,  lat: 5,  res: 32'sd0,          err: 1'b0, cyc: 3,  starts: 0};
    vecs[2] = '{a: -16'sd32768, b: -16'sd32768, lat: 8,  res: 32'sd1073741824, err: 1'b0, cyc: 11, starts: 1};
    vecs[3] = '{a: -16'sd32768, b:  16'sd1,     lat: 3,  res: -32'sd32768,     err: 1'b0, cyc: 6,  starts: 1};
    vecs[4] = '{a:  16'sd7,     b:  16'sd0,     lat: 5,  res: 32'sd0,          err: 1'b0, cyc: 3,  starts: 0};
    vecs[5] = '{a:  16'sd32767, b:  16'sd32767, lat: 2,  res: 32'sd1073676289, err: 1'b0, cyc: 5,  starts: 1};
    vecs[6] = '{a:  16'sd55,    b: -16'sd2,     lat: 0,  res: 32'sd0,          err: 1'b1, cyc: 67, starts: 1};
    vecs[7] = '{a: -16'sd9,     b: -16'sd11,    lat: 20, res: 32'sd99,         err: 1'b0, cyc: 23, starts: 1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({mul_start, out_valid, out_err, busy, in_ready}), 32'b00001);
    check("rst_ops", {mul_multiplicand, mul_multiplier}, 32'd0);
    check("rst_result", out_result, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("vec_ops_stable", 32'(op_changed), 32'd0);

    // Asynchronous reset while a job sits in WAIT.
    lat_cfg = 34;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'sd21;
    in_b     = -16'sd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 32'({busy, mul_start}), 32'b10);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ctrl", 32'({mul_start, out_valid, out_err, busy, in_ready}), 32'b00001);
    check("mid_rst_ops", {mul_multiplicand, mul_multiplier}, 32'd0);
    check("mid_rst_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[7], "post_rst");

    // Hold a product with out_ready low while the FIFO fills behind it.
    stale_cfg = 1'b1;
    lat_cfg   = 5;
    out_ready = 1'b0;
    s0 = start_count;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'sd2;
    in_b     = 16'sd3;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("hold_first");
    check("hold_first_result", out_result, 32'sd6);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_in_ready%0d", i), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = burst_a[i];
      in_b     = burst_b[i];
      @(negedge clk);
    end
    check("burst_full_in_ready", 32'(in_ready), 32'd0);
    in_a = 16'sd1;
    in_b = 16'sd1;
    for (int i = 0; i < 10; i++) begin
      check("hold_result_stable", out_result, 32'sd6);
      @(negedge clk);
    end
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_no_start", 32'(start_count - s0), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("burst%0d", i));
      check($sformatf("burst%0d_result", i), out_result,
            (burst_a[i] == 0 || burst_b[i] == 0) ? 32'd0 : ref_prod(burst_a[i], burst_b[i]));
      check($sformatf("burst%0d_err", i), 32'(out_err), 32'd0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("burst_idle", 32'({busy, out_valid, in_ready}), 32'b001);
    check("burst_starts", 32'(start_count - s0), 32'd4);
    check("burst_ops_stable", 32'(op_changed), 32'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 800; i++) rand_cycle(1'b0);
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      rand_cycle(1'b1);
      n++;
    end
    check("rnd_drain_results", 32'(exp_q.size()), 32'd0);
    check("rnd_drain_starts", 32'(op_q.size()), 32'd0);
    check("rnd_final_idle", 32'({busy, in_ready}), 32'b01);
    check("rnd_ops_stable", 32'(op_changed), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
